sort_job_ctrl: RTL
==================

// Module: sort_job_ctrl
// PURPOSE
// Job sequencer in front of the insertion_sort engine. Accepts one job as a
// valid/ready word stream terminated by in_last, then drives the engine's
// edge-triggered strobes: clear, push each word, sort, pop each word. Results
// leave as a valid/ready stream in descending order (the engine pops its top
// entry first).
// PARAMETERS
// DW        16    data width; must match engine
// DEPTH     255   max words per job (engine full point)
// CMD_WAIT  3     enabled cycles after strobe before polling srt_idle
// TIMEOUT   65535 enabled cycles allowed per command before abort
// PORTS
// clk        in   1   clock, rising edge
// rstn       in   1   async active-low reset, shared with engine
// enable     in   1   clock enable; 0 freezes all state (tie to engine enable)
// in_valid   in   1   job word valid
// in_ready   out  1   job word accepted when in_valid&in_ready
// in_data    in   DW  job word
// in_last    in   1   final word of job
// out_valid  out  1   result word valid
// out_ready  in   1   downstream accepts result
// out_data   out  DW  result word
// out_last   out  1   final result word
// busy       out  1   state != S_IDLE
// done       out  1   one-cycle pulse on job completion
// err_ovf    out  1   sticky: job exceeded DEPTH words; cleared at job start
// err_tmo    out  1   sticky: command timeout; cleared at job start
// srt_push/srt_pop/srt_clear/srt_sort  out 1  engine strobes
// srt_din    out  DW  engine write data
// srt_dout   in   DW  engine read data
// srt_idle   in   1   engine idle
// BEHAVIOUR
// - Reset: all outputs 0, state S_IDLE, cnt=0, rem=0, phase/watchdog=0.
// - All registers advance only on clk edges with enable=1.
// - Command issue (CLR/PUSH/SORT/POP): strobe high exactly 1 cycle, low for
//   CMD_WAIT cycles, then wait srt_idle=1; then command complete. Strobes are
//   registered; at most one high at a time. srt_din held stable from push
//   strobe to completion.
// - Watchdog counts cycles from strobe; reaching TIMEOUT: err_tmo=1, go S_IDLE,
//   no done pulse, pending results discarded.
// - S_IDLE: in_ready=0; in_valid=1 -> clear err_*, cnt=0, -> S_CLR.
// - S_CLR: issue clear -> S_LOAD.
// - S_LOAD: in_ready=1; on handshake latch in_data->srt_din, last flag -> S_PUSH.
// - S_PUSH: issue push; cnt++. last -> S_SORT; else cnt==DEPTH -> err_ovf=1,
//   S_DRAIN; else S_LOAD.
// - S_DRAIN: in_ready=1, discard words until in_last handshake -> S_SORT.
// - S_SORT: rem=cnt; if cnt<2 skip sort (engine mis-sorts 0/1 entries);
//   cnt>=2 issue sort. -> S_POP (cnt>=1) or S_DONE (cnt==0).
// - S_POP: issue pop; on completion latch srt_dout->out_data -> S_OUT.
// - S_OUT: out_valid=1, out_last=(rem==1); out_data stable until handshake;
//   handshake: rem--, rem==1 -> S_DONE else S_POP.
// - S_DONE: done=1 for one cycle -> S_IDLE.
// - in_valid while busy outside LOAD/DRAIN: in_ready=0, stream stalls.
// - out_ready without out_valid: ignored. enable=0: strobes, done hold value.
// - Reset mid-job: immediate abort to reset values; engine resets with it.
// - cnt/rem are 8 bits for DEPTH=255; no wrap possible.
// TESTING
// - Job 5,1,4,2,3(last) -> out 5,4,3,2,1, out_last on 1, one done pulse.
// - Single word 0x00AA(last) -> no srt_sort strobe; out 0x00AA, out_last=1.
// - 256 words 0..255 -> err_ovf=1, word 255 dropped; out 254..0, done.
// - out_ready low 10 cycles on 2nd result -> out_data/out_valid held, no pop.
// - srt_idle forced 0 after push -> err_tmo after TIMEOUT cycles, S_IDLE.
// - rstn low during S_OUT -> all outputs 0, new job 3,9(last) -> out 9,3.

Source files
------------

// File: rtl/sort_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sort_job_ctrl
// Brief  : Job sequencer for the insertion_sort engine. Loads one job word by
//          word, sorts it and streams the result back in descending order.
// Rev    : 1.0  initial release
// ============================================================================
module sort_job_ctrl #(
    parameter int DW       = 16,
    parameter int DEPTH    = 255,
    parameter int CMD_WAIT = 3,
    parameter int TIMEOUT  = 65535
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err_ovf,
    output logic          err_tmo,
    output logic          srt_push,
    output logic          srt_pop,
    output logic          srt_clear,
    output logic          srt_sort,
    output logic [DW-1:0] srt_din,
    input  logic [DW-1:0] srt_dout,
    input  logic          srt_idle
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int WW = (CMD_WAIT < 1) ? 1 : $clog2(CMD_WAIT + 1);

    localparam logic [CW-1:0] c_depth     = CW'(DEPTH);
    localparam logic [TW-1:0] c_tmo_last  = TW'(TIMEOUT - 1);
    localparam logic [WW-1:0] c_wait_last = WW'(CMD_WAIT);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CLR   = 4'd1;
    localparam logic [3:0] S_LOAD  = 4'd2;
    localparam logic [3:0] S_PUSH  = 4'd3;
    localparam logic [3:0] S_DRAIN = 4'd4;
    localparam logic [3:0] S_SORT  = 4'd5;
    localparam logic [3:0] S_POP   = 4'd6;
    localparam logic [3:0] S_OUT   = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    localparam logic [1:0] P_ISSUE = 2'd0;
    localparam logic [1:0] P_WAIT  = 2'd1;
    localparam logic [1:0] P_POLL  = 2'd2;

    logic [3:0]    state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [WW-1:0] wcnt_q,  wcnt_d;
    logic [TW-1:0] wd_q,    wd_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [CW-1:0] rem_q,   rem_d;
    logic          last_q,  last_d;
    logic [DW-1:0] din_q,   din_d;
    logic [DW-1:0] dout_q,  dout_d;
    logic          done_q,  done_d;
    logic          ovf_q,   ovf_d;
    logic          tmo_q,   tmo_d;
    logic          push_q,  push_d;
    logic          pop_q,   pop_d;
    logic          clr_q,   clr_d;
    logic          sort_q,  sort_d;

    logic cmd_active;
    logic cmd_done;
    logic cmd_tmo;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            phase_q <= P_ISSUE;
            wcnt_q  <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            din_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            clr_q   <= 1'b0;
            sort_q  <= 1'b0;
        end else if (enable) begin
            state_q <= state_d;
            phase_q <= phase_d;
            wcnt_q  <= wcnt_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            clr_q   <= clr_d;
            sort_q  <= sort_d;
        end
    end

    // A job of fewer than two words bypasses the engine's sort command.
    assign cmd_active = (state_q == S_CLR) || (state_q == S_PUSH) || (state_q == S_POP) ||
                        ((state_q == S_SORT) && (cnt_q >= CW'(2)));
    assign cmd_done   = (phase_q == P_POLL) && srt_idle;
    assign cmd_tmo    = (phase_q != P_ISSUE) && !cmd_done && (wd_q == c_tmo_last);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wcnt_d  = wcnt_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        last_d  = last_q;
        din_d   = din_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        push_d  = 1'b0;
        pop_d   = 1'b0;
        clr_d   = 1'b0;
        sort_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    cnt_d   = '0;
                    phase_d = P_ISSUE;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                if (cmd_done) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (in_valid) begin
                    din_d   = in_data;
                    last_d  = in_last;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (cmd_done) begin
                    cnt_d = cnt_q + CW'(1);
                    if (last_q) begin
                        state_d = S_SORT;
                    end else if ((cnt_q + CW'(1)) == c_depth) begin
                        ovf_d   = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (in_valid && in_last) state_d = S_SORT;
            end
            S_SORT: begin
                rem_d = cnt_q;
                if (cnt_q < CW'(2)) begin
                    state_d = (cnt_q == '0) ? S_DONE : S_POP;
                    done_d  = (cnt_q == '0);
                end else if (cmd_done) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                if (cmd_done) begin
                    dout_d  = srt_dout;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_POP;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Shared strobe / settle / poll sequence; the watchdog runs from the strobe cycle.
        if (cmd_active) begin
            case (phase_q)
                P_ISSUE: begin
                    phase_d = P_WAIT;
                    wcnt_d  = '0;
                    wd_d    = '0;
                    clr_d   = (state_q == S_CLR);
                    push_d  = (state_q == S_PUSH);
                    sort_d  = (state_q == S_SORT);
                    pop_d   = (state_q == S_POP);
                end
                P_WAIT: begin
                    wd_d = wd_q + TW'(1);
                    if (wcnt_q == c_wait_last) phase_d = P_POLL;
                    else                       wcnt_d  = wcnt_q + WW'(1);
                end
                default: wd_d = wd_q + TW'(1);
            endcase
            if (cmd_done) phase_d = P_ISSUE;
            if (cmd_tmo) begin
                tmo_d   = 1'b1;
                phase_d = P_ISSUE;
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == S_LOAD) || (state_q == S_DRAIN);
        out_valid = (state_q == S_OUT);
        out_last  = (state_q == S_OUT) && (rem_q == CW'(1));
        busy      = (state_q != S_IDLE);
    end

    assign out_data  = dout_q;
    assign srt_din   = din_q;
    assign done      = done_q;
    assign err_ovf   = ovf_q;
    assign err_tmo   = tmo_q;
    assign srt_push  = push_q;
    assign srt_pop   = pop_q;
    assign srt_clear = clr_q;
    assign srt_sort  = sort_q;

endmodule
`default_nettype wire
